// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: widths, frame header
// bytes, FSM state encoding and a small state classification helper.
// Optional feature macro used by the design: UART_CMD_TIMEOUT_EN.
package uart_cmd_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int TO_CNT_W = 20;

  localparam logic [DATA_W-1:0] HDR_WR = 8'h55;
  localparam logic [DATA_W-1:0] HDR_RD = 8'hAA;

  // FSM state enumeration, kept as plain constants so the encoding is fixed
  // and visible on the debug port.
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_ADDR_H  = 4'd1;
  localparam state_t ST_ADDR_L  = 4'd2;
  localparam state_t ST_DATA    = 4'd3;
  localparam state_t ST_WR_REQ  = 4'd4;
  localparam state_t ST_RD_REQ  = 4'd5;
  localparam state_t ST_RD_WAIT = 4'd6;
  localparam state_t ST_TX_WAIT = 4'd7;
  localparam state_t ST_TX      = 4'd8;

  // True while a frame is being collected byte by byte.
  function automatic logic in_frame(input state_t st);
    return (st == ST_ADDR_H) || (st == ST_ADDR_L) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter. Counts cycles while enabled and not cleared;
// raises expired for one cycle on the TIMEOUT_CYC-th quiet cycle and restarts.
// Only instantiated when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W-1:0] cnt_d;

  // Next count and expiry flag; a clear or leaving the frame states resets it.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      expired = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses write (55 AH AL D) and read (AA AH AL)
// frames from a byte stream, issues level-held memory requests and returns
// read data through the UART transmitter. Invalid or dropped bytes are
// counted in a saturating error counter.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
//
// Handshakes: po_flag/rx_data is a one-cycle strobe with no backpressure.
// mem_wr_req/mem_rd_req rise one cycle after entering the request state and
// stay high (with stable mem_addr/mem_wdata) up to and including the cycle
// mem_ack is seen; mem_ack is only honoured while the request is high.
// tx_trig is a one-cycle strobe issued only after tx_busy was seen low;
// tx_data stays stable until the next read completes.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              po_flag,
  output logic              tx_trig,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        err_cnt,
  output logic [3:0]        dbg_state
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1048575) begin : g_bad_timeout
    $error("uart_cmd_ctrl: TIMEOUT_CYC out of range 2..2^20-1");
  end

  state_t            state_q,   state_d;
  logic              is_rd_q,   is_rd_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_trig_q, tx_trig_d;
  logic              wr_req_q,  wr_req_d;
  logic              rd_req_q,  rd_req_d;
  logic [7:0]        err_q,     err_d;
  logic              err_inc;
  logic              frame_active;
  logic              timeout_hit;

  assign frame_active = in_frame(state_q);

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (po_flag),
    .en      (frame_active),
    .expired (timeout_hit)
  );
`else
  // Without the timeout a partial frame waits for its next byte forever.
  assign timeout_hit = 1'b0;
`endif

  // Frame parsing, request sequencing and error accounting.
  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    tx_trig_d = 1'b0;
    wr_req_d  = 1'b0;
    rd_req_d  = 1'b0;
    err_inc   = 1'b0;

    // Bytes arriving while a transaction is in flight are dropped.
    if (po_flag && state_q != ST_IDLE && !frame_active) begin
      err_inc = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (po_flag) begin
          if (rx_data == HDR_WR) begin
            is_rd_d = 1'b0;
            state_d = ST_ADDR_H;
          end else if (rx_data == HDR_RD) begin
            is_rd_d = 1'b1;
            state_d = ST_ADDR_H;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      ST_ADDR_H: begin
        if (po_flag) begin
          addr_d[ADDR_W-1:8] = rx_data;
          state_d            = ST_ADDR_L;
        end else if (timeout_hit) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_L: begin
        if (po_flag) begin
          addr_d[7:0] = rx_data;
          state_d     = is_rd_q ? ST_RD_REQ : ST_DATA;
        end else if (timeout_hit) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (po_flag) begin
          wdata_d = rx_data;
          state_d = ST_WR_REQ;
        end else if (timeout_hit) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (wr_req_q && mem_ack) begin
          state_d = ST_IDLE;
        end else begin
          wr_req_d = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (rd_req_q && mem_ack) begin
          state_d = ST_RD_WAIT;
        end else begin
          rd_req_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          tx_trig_d = 1'b1;
          tx_data_d = rdata_q;
          state_d   = ST_TX;
        end
      end
      ST_TX: begin
        // The pulse cycle itself is skipped so the transmitter gets a
        // chance to raise busy before we look at it.
        if (!tx_trig_q && !tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_d = err_q;
    if (err_inc && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  // State and output registers; reset abandons any transaction at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tx_data_q <= '0;
      tx_trig_q <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tx_data_q <= tx_data_d;
      tx_trig_q <= tx_trig_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      err_q     <= err_d;
    end
  end

  assign tx_trig    = tx_trig_q;
  assign tx_data    = tx_data_q;
  assign mem_wr_req = wr_req_q;
  assign mem_rd_req = rd_req_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign err_cnt    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: table of frames with hand-computed results plus
// directed sequences for busy back-pressure, reset abort, error saturation
// and the inter-byte timeout (UART_CMD_TIMEOUT_EN).
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        po_flag;
  logic        tx_trig;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        mem_wr_req;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic [7:0]  err_cnt;
  logic [3:0]  dbg_state;

  // Environment-side sources, merged onto the DUT inputs.
  logic        model_busy, force_busy;
  logic        auto_ack, man_ack, auto_rvalid, man_rvalid;
  logic [7:0]  auto_rdata, man_rdata;
  logic        mem_auto;
  int          ack_dly;
  logic [7:0]  rd_byte;

  assign tx_busy    = model_busy | force_busy;
  assign mem_ack    = auto_ack | man_ack;
  assign mem_rvalid = auto_rvalid | man_rvalid;
  assign mem_rdata  = man_rvalid ? man_rdata : auto_rdata;

  uart_cmd_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .po_flag    (po_flag),
    .tx_trig    (tx_trig),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .mem_wr_req (mem_wr_req),
    .mem_rd_req (mem_rd_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_log [0:255];
  int          obs_n = 0;
  int          rd_ptr = 0;
  int          trig_cnt = 0;
  int          bad_trig = 0;
  int          both_cnt = 0;
  int          wr_run = 0;
  int          last_wr_len = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    po_flag = 1'b1;
    step();
    po_flag = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string name);
    int k;
    k = 0;
    while (dbg_state != st && k < budget) begin
      step();
      k++;
    end
    check(name, {28'h0, dbg_state}, {28'h0, st});
  endtask

  // Compare observed events, in order, against the expected queue.
  task automatic check_events(input string name);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_ptr < obs_n) begin
        check(name, obs_log[rd_ptr], e);
        rd_ptr++;
      end else begin
        check({name, "_missing"}, 32'h0, e);
      end
    end
    check({name, "_extra"}, 32'(obs_n - rd_ptr), 32'h0);
    rd_ptr = obs_n;
  endtask

  // ---------------- monitor ----------------
  // Events: {8'h57 'W', addr, wdata} on write accept, {8'h52 'R', addr, 0}
  // on read accept, {8'h54 'T', 0, tx_data} on each tx_trig.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_wr_req && mem_ack && obs_n < 256) begin
        obs_log[obs_n] = {8'h57, mem_addr, mem_wdata};
        obs_n++;
      end
      if (mem_rd_req && mem_ack && obs_n < 256) begin
        obs_log[obs_n] = {8'h52, mem_addr, 8'h00};
        obs_n++;
      end
      if (tx_trig) begin
        if (obs_n < 256) begin
          obs_log[obs_n] = {8'h54, 16'h0000, tx_data};
          obs_n++;
        end
        trig_cnt++;
        if (tx_busy) bad_trig++;
      end
      if (mem_wr_req && mem_rd_req) both_cnt++;
      if (mem_wr_req) begin
        wr_run++;
      end else if (wr_run != 0) begin
        last_wr_len = wr_run;
        wr_run = 0;
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    auto_ack = 1'b0;
    auto_rvalid = 1'b0;
    auto_rdata = 8'h00;
    forever begin
      step();
      if (mem_auto && (mem_wr_req || mem_rd_req)) begin
        automatic logic was_rd = mem_rd_req;
        repeat (ack_dly) step();
        auto_ack = 1'b1;
        step();
        auto_ack = 1'b0;
        if (was_rd) begin
          gap(2);
          auto_rdata  = rd_byte;
          auto_rvalid = 1'b1;
          step();
          auto_rvalid = 1'b0;
        end
      end
    end
  end

  // ---------------- transmitter model ----------------
  initial begin
    model_busy = 1'b0;
    forever begin
      step();
      if (tx_trig) begin
        step();
        model_busy = 1'b1;
        gap(8);
        model_busy = 1'b0;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          nb;
    int          ack_dly;
    logic [7:0]  rdata;
    int          n_ev;
    logic [31:0] ev0, ev1;
    logic [7:0]  exp_err;
    int          exp_wr_len;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  // ---------------- main sequence ----------------
  initial begin
    int          trig_before;
    logic [7:0]  bytes_v [4];

    rst = 1'b1;
    rx_data = 8'h00;
    po_flag = 1'b0;
    force_busy = 1'b0;
    man_ack = 1'b0;
    man_rvalid = 1'b0;
    man_rdata = 8'h00;
    mem_auto = 1'b1;
    ack_dly = 0;
    rd_byte = 8'h00;

    vecs[0] = '{8'h55, 8'h12, 8'h34, 8'hA5, 4, 3, 8'h00, 1, 32'h5712_34A5, 32'h0, 8'd0, 4};
    vecs[1] = '{8'hAA, 8'h00, 8'h10, 8'h00, 3, 1, 8'h3C, 2, 32'h5200_1000, 32'h5400_003C, 8'd0, 0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 32'h0, 32'h0, 8'd1, 0};
    vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 32'h0, 32'h0, 8'd2, 0};
    vecs[4] = '{8'h55, 8'h00, 8'h01, 8'h02, 4, 0, 8'h00, 1, 32'h5700_0102, 32'h0, 8'd2, 1};
    vecs[5] = '{8'hAA, 8'hFF, 8'hFF, 8'h00, 3, 2, 8'h81, 2, 32'h52FF_FF00, 32'h5400_0081, 8'd2, 0};
    vecs[6] = '{8'h55, 8'hAB, 8'hCD, 8'h00, 4, 5, 8'h00, 1, 32'h57AB_CD00, 32'h0, 8'd2, 6};
    vecs[7] = '{8'h12, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 32'h0, 32'h0, 8'd3, 0};

    gap(3);
    rst = 1'b0;

    // Reset state.
    check("rst_tx_trig", {31'h0, tx_trig}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_wr_req", {31'h0, mem_wr_req}, 32'h0);
    check("rst_rd_req", {31'h0, mem_rd_req}, 32'h0);
    check("rst_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_err", {24'h0, err_cnt}, 32'h0);
    check("rst_state", {28'h0, dbg_state}, {28'h0, ST_IDLE});

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      ack_dly = vecs[i].ack_dly;
      rd_byte = vecs[i].rdata;
      bytes_v = '{vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3};
      if (vecs[i].n_ev > 0) exp_q.push_back(vecs[i].ev0);
      if (vecs[i].n_ev > 1) exp_q.push_back(vecs[i].ev1);
      for (int j = 0; j < vecs[i].nb; j++) begin
        send_byte(bytes_v[j]);
        gap(3);
      end
      wait_state(ST_IDLE, 300, $sformatf("vec%0d_idle", i));
      gap(4);
      check_events($sformatf("vec%0d_ev", i));
      check($sformatf("vec%0d_err", i), {24'h0, err_cnt}, {24'h0, vecs[i].exp_err});
      if (vecs[i].exp_wr_len > 0)
        check($sformatf("vec%0d_wr_len", i), 32'(last_wr_len), 32'(vecs[i].exp_wr_len));
    end

    // Read with the transmitter held busy for 20 cycles.
    ack_dly = 1;
    rd_byte = 8'h3C;
    force_busy = 1'b1;
    exp_q.push_back(32'h5200_1000);
    exp_q.push_back(32'h5400_003C);
    send_byte(8'hAA); gap(2);
    send_byte(8'h00); gap(2);
    send_byte(8'h10);
    wait_state(ST_TX_WAIT, 100, "busy_reach_tx_wait");
    trig_before = trig_cnt;
    gap(20);
    check("busy_no_trig", 32'(trig_cnt - trig_before), 32'h0);
    check("busy_still_wait", {28'h0, dbg_state}, {28'h0, ST_TX_WAIT});
    force_busy = 1'b0;
    wait_state(ST_IDLE, 100, "busy_idle");
    gap(4);
    check("busy_one_trig", 32'(trig_cnt - trig_before), 32'h1);
    check_events("busy_ev");

    // Reset while a read request is pending; late handshakes are ignored.
    mem_auto = 1'b0;
    send_byte(8'hAA); gap(2);
    send_byte(8'h12); gap(2);
    send_byte(8'h34);
    begin
      int k;
      k = 0;
      while (!mem_rd_req && k < 20) begin step(); k++; end
    end
    check("abort_rd_req_seen", {31'h0, mem_rd_req}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rd_req", {31'h0, mem_rd_req}, 32'h0);
    check("abort_wr_req", {31'h0, mem_wr_req}, 32'h0);
    check("abort_tx_data", {24'h0, tx_data}, 32'h0);
    check("abort_addr", {16'h0, mem_addr}, 32'h0);
    check("abort_wdata", {24'h0, mem_wdata}, 32'h0);
    check("abort_err", {24'h0, err_cnt}, 32'h0);
    check("abort_state", {28'h0, dbg_state}, {28'h0, ST_IDLE});
    trig_before = trig_cnt;
    step();
    man_ack = 1'b1; step(); man_ack = 1'b0;
    gap(2);
    man_rdata = 8'h77;
    man_rvalid = 1'b1; step(); man_rvalid = 1'b0;
    gap(30);
    check("abort_no_trig", 32'(trig_cnt - trig_before), 32'h0);
    check("abort_idle", {28'h0, dbg_state}, {28'h0, ST_IDLE});
    check_events("abort_ev");
    mem_auto = 1'b1;

    // Error counter saturation.
    for (int k = 0; k < 254; k++) send_byte(8'h00);
    check("sat_254", {24'h0, err_cnt}, 32'd254);
    send_byte(8'h01);
    check("sat_255", {24'h0, err_cnt}, 32'd255);
    repeat (5) send_byte(8'hFE);
    check("sat_hold", {24'h0, err_cnt}, 32'd255);

    // Partial frame followed by silence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_byte(8'h55); gap(3);
    send_byte(8'h12);
`ifdef UART_CMD_TIMEOUT_EN
    gap(99);
    check("to_before_state", {28'h0, dbg_state}, {28'h0, ST_ADDR_L});
    check("to_before_err", {24'h0, err_cnt}, 32'd0);
    gap(1);
    check("to_after_state", {28'h0, dbg_state}, {28'h0, ST_IDLE});
    check("to_after_err", {24'h0, err_cnt}, 32'd1);
    ack_dly = 2;
    rd_byte = 8'h5A;
    exp_q.push_back(32'h5200_0000);
    exp_q.push_back(32'h5400_005A);
    send_byte(8'hAA); gap(3);
    send_byte(8'h00); gap(3);
    send_byte(8'h00);
    wait_state(ST_IDLE, 300, "to_read_idle");
    gap(4);
    check_events("to_read_ev");
    check("to_read_err", {24'h0, err_cnt}, 32'd1);
`else
    gap(150);
    check("noto_state", {28'h0, dbg_state}, {28'h0, ST_ADDR_L});
    check("noto_err", {24'h0, err_cnt}, 32'd0);
`endif

    check("trig_while_busy", 32'(bad_trig), 32'h0);
    check("wr_rd_overlap", 32'(both_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
